// File: rtl/overlap_frame_buffer_if.sv
// Sample-in / beat-out stream bundle for the overlap frame buffer.
interface overlap_frame_buffer_if #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PAD_SIZE = 512
);
  localparam int unsigned IDX_W = $clog2(PAD_SIZE);

  logic             in_valid_i;
  logic [WIDTH-1:0] in_data_i;
  logic             in_ready_o;
  logic             out_valid_o;
  logic [WIDTH-1:0] out_data_o;
  logic             out_ready_i;
  logic             out_last_o;
  logic [IDX_W-1:0] out_index_o;

  // Framer side: consumes samples, produces frame beats.
  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_last_o, out_index_o
  );

  // Environment side: produces samples, consumes frame beats.
  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_last_o, out_index_o
  );
endinterface

// File: rtl/overlap_frame_buffer.sv
// Overlapping framer: buffers FRAME_SIZE samples in a circular RAM, emits each frame
// zero-padded to PAD_SIZE beats, then takes HOP_SIZE new samples before the next frame.
module overlap_frame_buffer #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned FRAME_SIZE = 306,
  parameter int unsigned HOP_SIZE   = 123,
  parameter int unsigned PAD_SIZE   = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  overlap_frame_buffer_if.slave bus,
  output logic [15:0]           frame_count_o,
  output logic                  busy_o
);
  localparam int unsigned IDX_W = $clog2(PAD_SIZE);
  localparam int unsigned PTR_W = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
  localparam int unsigned CNT_W = $clog2(FRAME_SIZE + 1);
  // Wide enough for base_ptr + idx (both < PAD_SIZE) without overflow.
  localparam int unsigned SUM_W = IDX_W + 1;

  typedef enum logic [1:0] {
    StFill   = 2'd0,
    StEmit   = 2'd1,
    StRefill = 2'd2
  } state_e;

  state_e           r_state, w_state_next;
  logic [PTR_W-1:0] r_wr_ptr, w_wr_ptr_next;
  logic [PTR_W-1:0] r_base_ptr, w_base_ptr_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [IDX_W-1:0] r_idx, w_idx_next;
  logic [15:0]      r_frame_count, w_frame_count_next;
  logic [WIDTH-1:0] r_mem [FRAME_SIZE];

  logic             w_in_ready, w_out_valid;
  logic             w_in_hs, w_out_hs, w_mem_we;
  logic             w_cnt_last, w_idx_last, w_in_frame;
  logic [PTR_W-1:0] w_wr_ptr_inc, w_base_ptr_hop, w_rd_addr;
  logic [SUM_W-1:0] w_base_sum, w_rd_sum;

  assign w_in_ready  = (r_state == StFill) || (r_state == StRefill);
  assign w_out_valid = (r_state == StEmit);
  assign w_in_hs     = bus.in_valid_i & w_in_ready;
  assign w_out_hs    = w_out_valid & bus.out_ready_i;
  // Flush discards any sample offered in the same cycle.
  assign w_mem_we    = w_in_hs & ~flush_i;

  assign w_wr_ptr_inc = (r_wr_ptr == PTR_W'(FRAME_SIZE - 1)) ? '0 : r_wr_ptr + PTR_W'(1);

  assign w_base_sum     = SUM_W'(r_base_ptr) + SUM_W'(HOP_SIZE);
  assign w_base_ptr_hop = (w_base_sum >= SUM_W'(FRAME_SIZE)) ?
                          PTR_W'(w_base_sum - SUM_W'(FRAME_SIZE)) : PTR_W'(w_base_sum);

  // Fill needs the whole frame; refill only replaces the oldest HOP_SIZE samples.
  assign w_cnt_last = (r_state == StFill) ? (r_cnt == CNT_W'(FRAME_SIZE - 1)) :
                                            (r_cnt == CNT_W'(HOP_SIZE - 1));
  assign w_idx_last = (r_idx == IDX_W'(PAD_SIZE - 1));
  assign w_in_frame = (SUM_W'(r_idx) < SUM_W'(FRAME_SIZE));

  assign w_rd_sum  = SUM_W'(r_base_ptr) + SUM_W'(r_idx);
  assign w_rd_addr = !w_in_frame ? '0 :
                     (w_rd_sum >= SUM_W'(FRAME_SIZE)) ? PTR_W'(w_rd_sum - SUM_W'(FRAME_SIZE)) :
                                                        PTR_W'(w_rd_sum);

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = w_out_valid;
  assign bus.out_data_o  = (w_out_valid && w_in_frame) ? r_mem[w_rd_addr] : '0;
  assign bus.out_index_o = w_out_valid ? r_idx : '0;
  assign bus.out_last_o  = w_out_valid && w_idx_last;
  assign frame_count_o   = r_frame_count;
  assign busy_o          = w_out_valid;

  // Next-state logic: flush overrides everything, otherwise fill/emit/refill sequencing.
  always_comb begin
    w_state_next       = r_state;
    w_wr_ptr_next      = r_wr_ptr;
    w_base_ptr_next    = r_base_ptr;
    w_cnt_next         = r_cnt;
    w_idx_next         = r_idx;
    w_frame_count_next = r_frame_count;
    if (flush_i) begin
      w_state_next       = StFill;
      w_wr_ptr_next      = '0;
      w_base_ptr_next    = '0;
      w_cnt_next         = '0;
      w_idx_next         = '0;
      w_frame_count_next = '0;
    end else begin
      case (r_state)
        StFill, StRefill: begin
          if (w_in_hs) begin
            w_wr_ptr_next = w_wr_ptr_inc;
            if (w_cnt_last) begin
              w_cnt_next   = '0;
              w_state_next = StEmit;
            end else begin
              w_cnt_next = r_cnt + CNT_W'(1);
            end
          end
        end
        StEmit: begin
          if (w_out_hs) begin
            if (w_idx_last) begin
              w_idx_next         = '0;
              w_base_ptr_next    = w_base_ptr_hop;
              w_frame_count_next = r_frame_count + 16'd1;
              w_state_next       = StRefill;
            end else begin
              w_idx_next = r_idx + IDX_W'(1);
            end
          end
        end
        default: w_state_next = StFill;
      endcase
    end
  end

  // State and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StFill;
      r_wr_ptr      <= '0;
      r_base_ptr    <= '0;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_frame_count <= '0;
    end else begin
      r_state       <= w_state_next;
      r_wr_ptr      <= w_wr_ptr_next;
      r_base_ptr    <= w_base_ptr_next;
      r_cnt         <= w_cnt_next;
      r_idx         <= w_idx_next;
      r_frame_count <= w_frame_count_next;
    end
  end

  // Sample RAM; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_wr_ptr] <= bus.in_data_i;
    end
  end
endmodule

// File: tb/tb_overlap_frame_buffer.sv
// Directed bench for overlap_frame_buffer: three parameter sets share one clock and stimulus,
// a selector chooses which instance is observed.
module tb_overlap_frame_buffer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        t_flush;
  logic        t_in_valid;
  logic [15:0] t_in_data;
  logic        t_out_ready;

  always #5 clk = ~clk;

  overlap_frame_buffer_if #(.WIDTH(16), .PAD_SIZE(512)) if_a ();
  overlap_frame_buffer_if #(.WIDTH(16), .PAD_SIZE(8))   if_b ();
  overlap_frame_buffer_if #(.WIDTH(16), .PAD_SIZE(16))  if_c ();

  logic [15:0] fc_a, fc_b, fc_c;
  logic        busy_a, busy_b, busy_c;

  assign if_a.in_valid_i  = t_in_valid;
  assign if_a.in_data_i   = t_in_data;
  assign if_a.out_ready_i = t_out_ready;
  assign if_b.in_valid_i  = t_in_valid;
  assign if_b.in_data_i   = t_in_data;
  assign if_b.out_ready_i = t_out_ready;
  assign if_c.in_valid_i  = t_in_valid;
  assign if_c.in_data_i   = t_in_data;
  assign if_c.out_ready_i = t_out_ready;

  overlap_frame_buffer #(.WIDTH(16), .FRAME_SIZE(306), .HOP_SIZE(123), .PAD_SIZE(512)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush_i(t_flush), .bus(if_a),
    .frame_count_o(fc_a), .busy_o(busy_a)
  );
  overlap_frame_buffer #(.WIDTH(16), .FRAME_SIZE(8), .HOP_SIZE(8), .PAD_SIZE(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush_i(t_flush), .bus(if_b),
    .frame_count_o(fc_b), .busy_o(busy_b)
  );
  overlap_frame_buffer #(.WIDTH(16), .FRAME_SIZE(8), .HOP_SIZE(1), .PAD_SIZE(16)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .flush_i(t_flush), .bus(if_c),
    .frame_count_o(fc_c), .busy_o(busy_c)
  );

  int sel;
  int cfg_f, cfg_h, cfg_p;
  int total, bad;

  logic        m_out_valid, m_out_last, m_in_ready, m_busy;
  logic [15:0] m_out_data, m_fc;
  int          m_out_index;

  // Route the selected instance's outputs to the checking signals.
  always_comb begin
    m_out_valid = 1'b0;
    m_out_last  = 1'b0;
    m_in_ready  = 1'b0;
    m_busy      = 1'b0;
    m_out_data  = '0;
    m_fc        = '0;
    m_out_index = 0;
    case (sel)
      0: begin
        m_out_valid = if_a.out_valid_o; m_out_last = if_a.out_last_o;
        m_in_ready  = if_a.in_ready_o;  m_busy     = busy_a;
        m_out_data  = if_a.out_data_o;  m_fc       = fc_a;
        m_out_index = int'(if_a.out_index_o);
      end
      1: begin
        m_out_valid = if_b.out_valid_o; m_out_last = if_b.out_last_o;
        m_in_ready  = if_b.in_ready_o;  m_busy     = busy_b;
        m_out_data  = if_b.out_data_o;  m_fc       = fc_b;
        m_out_index = int'(if_b.out_index_o);
      end
      default: begin
        m_out_valid = if_c.out_valid_o; m_out_last = if_c.out_last_o;
        m_in_ready  = if_c.in_ready_o;  m_busy     = busy_c;
        m_out_data  = if_c.out_data_o;  m_fc       = fc_c;
        m_out_index = int'(if_c.out_index_o);
      end
    endcase
  end

  // Reference model state
  int g_start;      // value of the first sample of the stream
  int g_next;       // next sample value to offer
  int g_frames;     // frames fully emitted since reset/flush
  int g_beat;       // beat index within the current frame
  int g_fill_left;  // samples still needed before the next frame is emitted

  localparam logic [45:0] RstVec = 46'd1;  // only in_ready high

  function automatic logic [45:0] obs_vec();
    logic [9:0] idx;
    idx = m_out_index[9:0];
    return {m_out_valid, m_out_last, idx, m_out_data, m_fc, m_busy, m_in_ready};
  endfunction

  function automatic logic [15:0] exp_data(input int f, input int b);
    if (b < cfg_f) return 16'(g_start + cfg_h * f + b);
    return 16'd0;
  endfunction

  task automatic select_cfg(input int s);
    sel = s;
    case (s)
      0:       begin cfg_f = 306; cfg_h = 123; cfg_p = 512; end
      1:       begin cfg_f = 8;   cfg_h = 8;   cfg_p = 8;   end
      default: begin cfg_f = 8;   cfg_h = 1;   cfg_p = 16;  end
    endcase
  endtask

  task automatic model_init(input int start);
    g_start     = start;
    g_next      = start;
    g_frames    = 0;
    g_beat      = 0;
    g_fill_left = cfg_f;
  endtask

  // Drive samples/ready and check every cycle against the model until nframes more are emitted.
  task automatic run_frames(input int nframes, input bit rnd);
    int    target, budget, cyc;
    bit    exp_v;
    logic [15:0] exp_d;
    target = g_frames + nframes;
    budget = nframes * (cfg_p + cfg_f) * 3 + 2000;
    cyc    = 0;
    while (g_frames < target && cyc < budget && bad < 50) begin
      @(negedge clk);
      cyc++;
      exp_v = (g_fill_left == 0);
      total++;
      if (m_out_valid !== exp_v || m_in_ready !== !exp_v || m_busy !== exp_v) begin
        bad++;
        $display("FAIL state frame=%0d beat=%0d: valid=%b ready=%b busy=%b, want valid=%b ready=%b",
                 g_frames, g_beat, m_out_valid, m_in_ready, m_busy, exp_v, !exp_v);
      end
      if (exp_v) begin
        exp_d = exp_data(g_frames, g_beat);
        total++;
        if (m_out_data !== exp_d) begin
          bad++;
          $display("FAIL data frame=%0d beat=%0d: got %0d want %0d", g_frames, g_beat,
                   m_out_data, exp_d);
        end
        total++;
        if (m_out_index != g_beat) begin
          bad++;
          $display("FAIL index frame=%0d: got %0d want %0d", g_frames, m_out_index, g_beat);
        end
        total++;
        if (m_out_last !== (g_beat == cfg_p - 1)) begin
          bad++;
          $display("FAIL last frame=%0d beat=%0d: got %b want %b", g_frames, g_beat, m_out_last,
                   (g_beat == cfg_p - 1));
        end
      end
      total++;
      if (m_fc !== 16'(g_frames)) begin
        bad++;
        $display("FAIL frame_count: got %0d want %0d", m_fc, 16'(g_frames));
      end
      t_out_ready = rnd ? ($urandom_range(0, 9) < 6) : 1'b1;
      t_in_valid  = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
      t_in_data   = 16'(g_next);
      if (t_in_valid && !exp_v) begin
        g_next++;
        g_fill_left--;
      end
      if (exp_v && t_out_ready) begin
        g_beat++;
        if (g_beat == cfg_p) begin
          g_beat      = 0;
          g_frames++;
          g_fill_left = cfg_h;
        end
      end
    end
    if (g_frames < target) begin
      total++;
      bad++;
      $display("FAIL run_frames: frames seen %0d want %0d within %0d cycles", g_frames, target,
               budget);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    t_in_valid  = 1'b0;
    t_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (obs_vec() !== RstVec) begin
      bad++;
      $display("FAIL reset_hold: got %h want %h", obs_vec(), RstVec);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (obs_vec() !== RstVec) begin
      bad++;
      $display("FAIL reset_release: got %h want %h", obs_vec(), RstVec);
    end
    model_init(1);
  endtask

  task automatic test_first_frame();
    run_frames(1, 1'b0);
    go_idle();
    total++;
    if (m_fc !== 16'd1 || m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL first_frame_end: fc=%0d valid=%b ready=%b want fc=1 valid=0 ready=1", m_fc,
               m_out_valid, m_in_ready);
    end
  endtask

  task automatic test_second_frame();
    run_frames(1, 1'b0);
    go_idle();
    total++;
    if (m_fc !== 16'd2) begin
      bad++;
      $display("FAIL second_frame_count: got %0d want 2", m_fc);
    end
  endtask

  task automatic test_stalls();
    run_frames(20, 1'b1);
    go_idle();
  endtask

  task automatic test_wrap();
    run_frames(6, 1'b0);
    go_idle();
    total++;
    if (m_fc !== 16'd28) begin
      bad++;
      $display("FAIL wrap_frame_count: got %0d want 28", m_fc);
    end
  endtask

  task automatic test_flush();
    int cyc;
    bit found;
    cyc   = 0;
    found = 1'b0;
    while (!found && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (m_out_valid === 1'b1 && m_out_index == 100) begin
        found = 1'b1;
      end else begin
        t_in_valid  = 1'b1;
        t_in_data   = 16'hBEEF;
        t_out_ready = 1'b1;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL flush_reach_beat100: got no beat 100 want beat 100 within 5000 cycles");
    end
    t_flush     = 1'b1;
    t_in_valid  = 1'b1;
    t_in_data   = 16'hDEAD;
    t_out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (obs_vec() !== RstVec) begin
      bad++;
      $display("FAIL flush_next_cycle: got %h want %h", obs_vec(), RstVec);
    end
    // Flush again while in_ready is high: the offered sample must be dropped.
    @(negedge clk);
    t_flush    = 1'b0;
    t_in_valid = 1'b0;
    t_out_ready = 1'b0;
    model_init(1001);
    run_frames(1, 1'b0);
    go_idle();
    total++;
    if (m_fc !== 16'd1) begin
      bad++;
      $display("FAIL flush_refill_count: got %0d want 1", m_fc);
    end
  endtask

  task automatic test_small_config(input int s);
    int cyc;
    bit found;
    select_cfg(s);
    @(negedge clk);
    rst_n       = 1'b0;
    t_in_valid  = 1'b0;
    t_out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_init(1);
    run_frames(4, 1'b1);
    cyc   = 0;
    found = 1'b0;
    while (!found && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (m_out_valid === 1'b1 && m_out_index == 3) begin
        found = 1'b1;
      end else begin
        t_in_valid  = 1'b1;
        t_in_data   = 16'h5A5A;
        t_out_ready = 1'b1;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL cfg%0d_reach_emit: got no beat 3 want beat 3 within 500 cycles", s);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (obs_vec() !== RstVec) begin
      bad++;
      $display("FAIL cfg%0d_reset_mid_emit: got %h want %h", s, obs_vec(), RstVec);
    end
    @(negedge clk);
    t_in_valid  = 1'b0;
    t_out_ready = 1'b0;
    rst_n       = 1'b1;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    t_flush     = 1'b0;
    t_in_valid  = 1'b0;
    t_in_data   = '0;
    t_out_ready = 1'b0;
    select_cfg(0);
    test_reset();
    test_first_frame();
    test_second_frame();
    test_stalls();
    test_wrap();
    test_flush();
    test_small_config(1);
    test_small_config(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at 2 ms want finished");
    $fatal(1, "watchdog expired");
  end
endmodule
